// File: rtl/bounce_generator.sv
// Turns a clean target level into a deterministic LFSR-timed glitch burst; first edge 1 cycle after a target change, done after burst + SETTLE_CYCLES.
// No backpressure: target/enable changes during a sequence are deferred until it completes.
module bounce_generator #(
    parameter int unsigned BOUNCES       = 4,
    parameter int unsigned GLITCH_W      = 3,
    parameter int unsigned SETTLE_CYCLES = 10,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic target,
    output logic noisysignal,
    output logic busy,
    output logic done
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam int unsigned GMAX     = 1 << GLITCH_W;
    localparam int unsigned TMAX     = (GMAX > SETTLE_CYCLES) ? GMAX : SETTLE_CYCLES;
    localparam int          TW       = $clog2(TMAX + 1);
    localparam int unsigned NTOG     = 2 * BOUNCES;
    localparam int          CW       = (NTOG > 0) ? $clog2(NTOG + 1) : 1;
    localparam logic [CW-1:0] LAST_TOG  = CW'(NTOG);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic          goal;
    logic [TW-1:0] timer;
    logic [TW-1:0] glitch_len;
    logic [CW-1:0] toggles;

    assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign glitch_len = TW'(lfsr[GLITCH_W-1:0]) + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= SEED_EFF;
            goal        <= 1'b0;
            timer       <= '0;
            toggles     <= '0;
            noisysignal <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (enable && (target != goal)) begin
                        goal        <= target;
                        noisysignal <= target;
                        busy        <= 1'b1;
                        toggles     <= '0;
                        if (NTOG == 0) begin
                            state <= SETTLE;
                            timer <= SETTLE_LD;
                        end else begin
                            state <= BOUNCE;
                            timer <= glitch_len;
                        end
                    end else if (!enable) begin
                        noisysignal <= target;
                        goal        <= target;
                    end
                end
                BOUNCE: begin
                    if (timer == TW'(1)) begin
                        noisysignal <= ~noisysignal;
                        toggles     <= toggles + CW'(1);
                        // An even number of toggles leaves the line back at goal.
                        if (toggles + CW'(1) == LAST_TOG) begin
                            state <= SETTLE;
                            timer <= SETTLE_LD;
                        end else begin
                            timer <= glitch_len;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                SETTLE: begin
                    noisysignal <= goal;
                    if (timer == TW'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: vector table, directed multi-cycle sequences, and a randomized run against a schedule-based model.
`timescale 1ns/1ps
module tb_bounce_generator;
    localparam int B  = 4;
    localparam int GW = 3;
    localparam int SC = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic enable  = 1'b1;
    logic target  = 1'b1;
    logic target0 = 1'b0;
    logic noisysignal, busy, done;
    logic noisy0, busy0, done0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bounce_generator #(.BOUNCES(B), .GLITCH_W(GW), .SETTLE_CYCLES(SC), .SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .target(target),
        .noisysignal(noisysignal), .busy(busy), .done(done)
    );

    bounce_generator #(.BOUNCES(0), .GLITCH_W(GW), .SETTLE_CYCLES(SC), .SEED(16'hACE1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .target(target0),
        .noisysignal(noisy0), .busy(busy0), .done(done0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: on each accepted request, precompute the full output
    // schedule (level, busy, done per cycle) from the LFSR sequence.
    typedef struct packed {
        logic n;
        logic b;
        logic d;
    } obs_t;

    obs_t        sched[$];
    obs_t        m     = '0;
    logic [15:0] ml    = 16'hACE1;
    logic        mgoal = 1'b0;

    function automatic logic [15:0] step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic plan(input logic lvl0, input logic [15:0] l0);
        logic        lvl;
        logic [15:0] lf;
        int          d;
        lvl = lvl0;
        lf  = l0;
        for (int k = 0; k < 2 * B; k++) begin
            d = int'(lf[GW-1:0]) + 1;
            for (int j = 1; j <= d; j++) begin
                lf = step(lf);
                if (j == d) lvl = ~lvl;
                sched.push_back('{lvl, 1'b1, 1'b0});
            end
        end
        for (int j = 1; j < SC; j++) sched.push_back('{lvl, 1'b1, 1'b0});
        sched.push_back('{lvl, 1'b0, 1'b1});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m     = '0;
            ml    = 16'hACE1;
            mgoal = 1'b0;
            sched.delete();
        end else begin
            if (sched.size() > 0) begin
                m = sched.pop_front();
            end else if (enable && (target != mgoal)) begin
                mgoal = target;
                m     = '{target, 1'b1, 1'b0};
                plan(target, ml);
            end else if (!enable) begin
                mgoal = target;
                m     = '{target, 1'b0, 1'b0};
            end else begin
                m = '{m.n, 1'b0, 1'b0};
            end
            ml = step(ml);
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({noisysignal, busy, done} !== m) begin
            errors++;
            $display("FAIL model t=%0t: got n/b/d=%b%b%b, expected %b", $time, noisysignal, busy, done, m);
        end
    end

    // Edge/interval tracker for one sequence, stops at the done sample.
    int   edges, since, minint, maxint;
    logic lastn;
    bit   timed_out;

    task automatic track(input bit sel, input int budget);
        logic n, dn;
        edges     = 0;
        since     = 0;
        minint    = 1000;
        maxint    = 0;
        timed_out = 1'b0;
        lastn     = sel ? noisy0 : noisysignal;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            n  = sel ? noisy0 : noisysignal;
            dn = sel ? done0 : done;
            if (n !== lastn) begin
                if (edges > 0) begin
                    if (since + 1 < minint) minint = since + 1;
                    if (since + 1 > maxint) maxint = since + 1;
                end
                edges++;
                since = 0;
            end else begin
                since++;
            end
            lastn = n;
            if (dn === 1'b1) return;
        end
        timed_out = 1'b1;
        checks++;
        errors++;
        $display("FAIL track_timeout: no done within %0d cycles", budget);
    endtask

    typedef struct {
        logic en;
        logic tg;
        logic n;
        logic b;
        logic d;
    } vec_t;

    vec_t tbl[6];
    int   anybusy, anydone;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset held with a pending request.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_noisy", noisysignal, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        target = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        check("idle_noisy", noisysignal, 0);

        // Vector table: bypass, no-op request, then a real request.
        for (int i = 0; i < 6; i++) begin
            enable = tbl[i].en;
            target = tbl[i].tg;
            @(negedge clk);
            check($sformatf("vec%0d_noisy", i), noisysignal, tbl[i].n);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].b);
            check($sformatf("vec%0d_done", i), done, tbl[i].d);
        end
        track(1'b0, 300);
        check("vec_seq_final", lastn, 0);
        check("vec_seq_edges", edges, 2 * B);

        // Target reverts mid-bounce: first sequence completes, second follows.
        target = 1'b1;
        @(negedge clk);
        check("rev_start_noisy", noisysignal, 1);
        check("rev_start_busy", busy, 1);
        target = 1'b0;
        track(1'b0, 300);
        check("rev_first_final", lastn, 1);
        @(negedge clk);
        check("rev_restart_busy", busy, 1);
        check("rev_restart_noisy", noisysignal, 0);
        track(1'b0, 300);
        check("rev_second_final", lastn, 0);
        check("rev_second_edges", edges, 2 * B);

        // Full 0->1 sequence shape.
        target = 1'b1;
        track(1'b0, 300);
        check("seq_edges", edges, 2 * B + 1);
        check("seq_min_interval_ok", minint >= 1, 1);
        check("seq_max_interval_ok", maxint <= (1 << GW), 1);
        check("seq_settle", since, SC);
        check("seq_final", lastn, 1);
        check("seq_busy_at_done", busy, 0);
        @(negedge clk);
        check("seq_done_one_cycle", done, 0);

        // Clean bypass, 20-cycle spacing.
        enable  = 1'b0;
        target  = 1'b0;
        check("byp_pre_edge", noisysignal, 1);
        edges   = 0;
        anybusy = 0;
        anydone = 0;
        lastn   = noisysignal;
        for (int c = 0; c < 40; c++) begin
            if (c == 20) target = 1'b1;
            @(negedge clk);
            if (c == 0) check("byp_latency", noisysignal, 0);
            if (noisysignal !== lastn) edges++;
            lastn = noisysignal;
            if (busy) anybusy++;
            if (done) anydone++;
        end
        check("byp_edges", edges, 2);
        check("byp_busy", anybusy, 0);
        check("byp_done", anydone, 0);

        // BOUNCES=0 instance: single clean edge then settle.
        enable  = 1'b1;
        target0 = 1'b1;
        track(1'b1, 100);
        check("b0_edges", edges, 1);
        check("b0_settle", since, SC);
        check("b0_final", lastn, 1);

        // Asynchronous reset while the line is high mid-sequence.
        target = 1'b0;
        begin
            int w;
            w = 0;
            @(negedge clk);
            while (noisysignal !== 1'b1 && w < 30) begin
                @(negedge clk);
                w++;
            end
            check("ar_found_high", noisysignal, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("ar_noisy", noisysignal, 0);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        target = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_restart_noisy", noisysignal, 1);
        check("ar_restart_busy", busy, 1);
        track(1'b0, 300);
        check("ar_final", lastn, 1);

        // Randomized target/enable activity against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) target = ~target;
            if ($urandom_range(0, 99) == 0) enable = ~enable;
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
